// File: rtl/tcb_lib_misalign_splitter.sv
// Splits misaligned MEMORY-mode TCB transfers into two aligned word transfers
// and merges the two read responses back into one subordinate response.
// Aligned transfers pass straight through with zero added latency.
module tcb_lib_misalign_splitter #(
  parameter  int unsigned ADR = 32,
  parameter  int unsigned BEN = 4,
  parameter  int unsigned DLY = 1,
  localparam int unsigned OFW = $clog2(BEN),
  localparam int unsigned SZW = $clog2(OFW + 1),
  localparam int unsigned DAT = 8 * BEN
) (
  input  logic           clk,
  input  logic           rst_n,
  // subordinate side (upstream converter)
  input  logic           sub_vld,
  output logic           sub_rdy_c,
  input  logic           sub_cmd,
  input  logic           sub_wen,
  input  logic           sub_ndn,
  input  logic [ADR-1:0] sub_adr,
  input  logic [SZW-1:0] sub_siz,
  input  logic [BEN-1:0] sub_ben,
  input  logic [DAT-1:0] sub_wdt,
  output logic [DAT-1:0] sub_rdt_c,
  output logic           sub_sts_c,
  // manager side (memory / peripheral)
  output logic           man_vld_c,
  input  logic           man_rdy,
  output logic           man_cmd_c,
  output logic           man_wen_c,
  output logic           man_ndn_c,
  output logic [ADR-1:0] man_adr_c,
  output logic [SZW-1:0] man_siz_c,
  output logic [BEN-1:0] man_ben_c,
  output logic [DAT-1:0] man_wdt_c,
  input  logic [DAT-1:0] man_rdt,
  input  logic           man_sts,
  // second part pending
  output logic           spl
);

  localparam int unsigned TAP = DLY - 1;

  if (DLY < 1) begin : g_dly_chk
    $error("tcb_lib_misalign_splitter: DLY must be at least 1");
  end

  typedef enum logic {IDLE, SECOND} state_t;

  state_t         state, state_nxt;
  logic [OFW-1:0] off, off_q;
  logic [BEN-1:0] low;
  logic           split;
  logic [ADR-1:0] base;
  logic           hs_fst, hs_snd;

  logic           trk_fst [DLY];
  logic           trk_snd [DLY];
  logic [OFW-1:0] trk_off [DLY];
  logic [DAT-1:0] rdt_buf;
  logic           sts_buf;

  // Fields that are identical in every part.
  assign man_cmd_c = sub_cmd;
  assign man_wen_c = sub_wen;
  assign man_ndn_c = sub_ndn;
  assign man_siz_c = sub_siz;
  assign man_wdt_c = sub_wdt;

  // Lanes below the address offset carry bytes of the following word.
  always_comb begin
    off = sub_adr[OFW-1:0];
    for (int i = 0; i < BEN; i++) low[i] = (OFW'(i) < off);
    split = (off != '0) && ((sub_ben & low) != '0);
    base  = {sub_adr[ADR-1:OFW], OFW'(0)};
  end

  // Next-state and request steering for the two-part sequence.
  always_comb begin
    state_nxt = state;
    man_vld_c = 1'b0;
    sub_rdy_c = 1'b0;
    man_adr_c = sub_adr;
    man_ben_c = sub_ben;
    hs_fst    = 1'b0;
    hs_snd    = 1'b0;
    case (state)
      IDLE: begin
        man_vld_c = sub_vld;
        if (split) begin
          man_adr_c = base;
          man_ben_c = sub_ben & ~low;
          hs_fst    = sub_vld & man_rdy;
          if (hs_fst) state_nxt = SECOND;
        end else begin
          sub_rdy_c = man_rdy;
        end
      end
      SECOND: begin
        man_vld_c = sub_vld;
        man_adr_c = base + ADR'(BEN);
        man_ben_c = sub_ben & low;
        sub_rdy_c = man_rdy;
        hs_snd    = sub_vld & man_rdy;
        if (hs_snd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      man_vld_c = 1'b0;
      sub_rdy_c = 1'b0;
      hs_fst    = 1'b0;
      hs_snd    = 1'b0;
    end
  end

  // State register, pending flag and latched offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      spl   <= 1'b0;
      off_q <= '0;
    end else begin
      state <= state_nxt;
      spl   <= (state_nxt == SECOND);
      if (hs_fst) off_q <= off;
    end
  end

  // In-flight tracker: marks which response cycles belong to split parts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) begin
        trk_fst[i] <= 1'b0;
        trk_snd[i] <= 1'b0;
        trk_off[i] <= '0;
      end
    end else begin
      trk_fst[0] <= hs_fst;
      trk_snd[0] <= hs_snd;
      trk_off[0] <= off_q;
      for (int i = 1; i < DLY; i++) begin
        trk_fst[i] <= trk_fst[i-1];
        trk_snd[i] <= trk_snd[i-1];
        trk_off[i] <= trk_off[i-1];
      end
    end
  end

  // Hold the first-part response until the second part returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdt_buf <= '0;
      sts_buf <= 1'b0;
    end else if (trk_fst[TAP]) begin
      rdt_buf <= man_rdt;
      sts_buf <= man_sts;
    end
  end

  // Response merge: upper lanes from the first word, lower lanes live.
  always_comb begin
    sub_rdt_c = man_rdt;
    sub_sts_c = man_sts;
    if (trk_snd[TAP]) begin
      for (int i = 0; i < BEN; i++) begin
        if (OFW'(i) >= trk_off[TAP]) sub_rdt_c[8*i +: 8] = rdt_buf[8*i +: 8];
      end
      sub_sts_c = sts_buf | man_sts;
    end
  end

endmodule
